// File: rtl/icsp_pkg.sv
// Shared constants for the PIC24 ICSP host sequencer: command codes, entry key
// and sequencer states.
package icsp_pkg;

  typedef enum logic [1:0] {
    OP_ENTER  = 2'd0,
    OP_SIX    = 2'd1,
    OP_REGOUT = 2'd2,
    OP_EXIT   = 2'd3
  } op_e;

  localparam logic [31:0] ICSP_KEY   = 32'h4D43_4851;
  localparam logic [3:0]  CMD_SIX    = 4'b0000;
  localparam logic [3:0]  CMD_REGOUT = 4'b0001;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_MCLR_LO   = 4'd1,
    ST_KEY       = 4'd2,
    ST_MCLR_WAIT = 4'd3,
    ST_SHIFT_CMD = 4'd4,
    ST_SHIFT_OUT = 4'd5,
    ST_TURN      = 4'd6,
    ST_SHIFT_IN  = 4'd7,
    ST_EXIT_LO   = 4'd8,
    ST_FIN       = 4'd9
  } state_e;

endpackage

// File: rtl/icsp_bitclk.sv
// PGC bit-clock: each bit is CLKDIV clk cycles low then CLKDIV high; the ticks
// mark the clk edge on which PGC rises or falls.
module icsp_bitclk #(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic pgc,
  output logic rise,
  output logic fall
);
  localparam logic [8:0] HALF_M1 = 9'(CLKDIV - 1);
  localparam logic [8:0] FULL_M1 = 9'(2 * CLKDIV - 1);

  logic [8:0] cnt_r;
  logic       pgc_r;

  assign rise = en && (cnt_r == HALF_M1);
  assign fall = en && (cnt_r == FULL_M1);
  assign pgc  = pgc_r;

  // Phase counter restarts at every bit boundary; PGC parks low when idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= 9'd0;
      pgc_r <= 1'b0;
    end else if (!en) begin
      cnt_r <= 9'd0;
      pgc_r <= 1'b0;
    end else begin
      if (fall) cnt_r <= 9'd0;
      else      cnt_r <= cnt_r + 9'd1;
      if (rise)      pgc_r <= 1'b1;
      else if (fall) pgc_r <= 1'b0;
      else           pgc_r <= pgc_r;
    end
  end

endmodule

// File: rtl/pic24_icsp_seq.sv
// PIC24 ICSP host sequencer: runs ENTER, SIX, REGOUT and EXIT commands on the
// PGC/PGD/MCLR pins of a target device.
module pic24_icsp_seq #(
  parameter int CLKDIV = 4,
  parameter int DLY    = 1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [23:0] instr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] dout,
  output logic        dvalid,
  output logic        PGCx,
  output logic        PGDx_out,
  input  logic        PGDx_in,
  output logic        PGDx_dir,
  output logic        MCLRn
);
  import icsp_pkg::*;

  localparam logic [16:0] DLY_M1  = 17'(DLY - 1);
  localparam logic [16:0] DLY2_M1 = 17'(2 * DLY - 1);

  state_e      state_r, state_s;
  op_e         op_r, op_s;
  logic [4:0]  bit_r, bit_s;
  logic [16:0] dly_r, dly_s;
  logic [23:0] instr_r, instr_s;
  logic [15:0] sh_r, sh_s, dout_r, dout_s;
  logic        rej_r, rej_s, entered_r, entered_s;
  logic        pgd_r, pgd_s, dir_r, dir_s, mclrn_r, mclrn_s;
  logic        busy_r, busy_s, done_r, done_s, err_r, err_s, dvalid_r, dvalid_s;
  logic        en_s, rise_s, fall_s, pgc_s;
  logic [3:0]  cmd_s;

  // A rejected command passes through SHIFT_CMD for one cycle without clocking.
  assign en_s  = (state_r inside {ST_KEY, ST_SHIFT_OUT, ST_TURN, ST_SHIFT_IN}) ||
                 ((state_r == ST_SHIFT_CMD) && !rej_r);
  assign cmd_s = (op_r == OP_REGOUT) ? CMD_REGOUT : CMD_SIX;

  icsp_bitclk #(.CLKDIV(CLKDIV)) u_bitclk (
    .clk  (clk),
    .rstn (rstn),
    .en   (en_s),
    .pgc  (pgc_s),
    .rise (rise_s),
    .fall (fall_s)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_s   = state_r;
    op_s      = op_r;
    bit_s     = bit_r;
    dly_s     = dly_r;
    instr_s   = instr_r;
    sh_s      = sh_r;
    dout_s    = dout_r;
    rej_s     = rej_r;
    entered_s = entered_r;
    pgd_s     = pgd_r;
    mclrn_s   = mclrn_r;
    dvalid_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_FIN: begin
        if (start) begin
          op_s    = op_e'(op);
          instr_s = instr;
          bit_s   = 5'd0;
          dly_s   = 17'd0;
          rej_s   = 1'b0;
          case (op_e'(op))
            OP_ENTER: begin
              state_s = ST_MCLR_LO;
              mclrn_s = 1'b0;
            end
            OP_EXIT: begin
              state_s = ST_EXIT_LO;
              mclrn_s = 1'b0;
            end
            default: begin
              state_s = ST_SHIFT_CMD;
              rej_s   = !entered_r;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MCLR_LO: begin
        if (dly_r == DLY_M1) begin
          state_s = ST_KEY;
          dly_s   = 17'd0;
        end else begin
          dly_s = dly_r + 17'd1;
        end
      end
      ST_KEY: begin
        if (rise_s) pgd_s = ICSP_KEY[5'd31 - bit_r];
        else        pgd_s = pgd_r;
        if (fall_s && (bit_r == 5'd31)) begin
          state_s = ST_MCLR_WAIT;
          bit_s   = 5'd0;
        end else if (fall_s) begin
          bit_s = bit_r + 5'd1;
        end else begin
          bit_s = bit_r;
        end
      end
      ST_MCLR_WAIT: begin
        // First DLY cycles hold MCLR low, the next DLY let the target settle.
        if (dly_r == DLY_M1) mclrn_s = 1'b1;
        else                 mclrn_s = mclrn_r;
        if (dly_r == DLY2_M1) begin
          state_s   = ST_FIN;
          entered_s = 1'b1;
        end else begin
          dly_s = dly_r + 17'd1;
        end
      end
      ST_SHIFT_CMD: begin
        if (rej_r) begin
          state_s = ST_FIN;
        end else begin
          if (rise_s) pgd_s = cmd_s[bit_r[1:0]];
          else        pgd_s = pgd_r;
          if (fall_s && (bit_r == 5'd3)) begin
            bit_s   = 5'd0;
            state_s = (op_r == OP_REGOUT) ? ST_TURN : ST_SHIFT_OUT;
          end else if (fall_s) begin
            bit_s = bit_r + 5'd1;
          end else begin
            bit_s = bit_r;
          end
        end
      end
      ST_SHIFT_OUT: begin
        if (rise_s) pgd_s = instr_r[bit_r];
        else        pgd_s = pgd_r;
        if (fall_s && (bit_r == 5'd23)) begin
          state_s = ST_FIN;
          bit_s   = 5'd0;
        end else if (fall_s) begin
          bit_s = bit_r + 5'd1;
        end else begin
          bit_s = bit_r;
        end
      end
      ST_TURN: begin
        if (fall_s && (bit_r == 5'd7)) begin
          state_s = ST_SHIFT_IN;
          bit_s   = 5'd0;
        end else if (fall_s) begin
          bit_s = bit_r + 5'd1;
        end else begin
          bit_s = bit_r;
        end
      end
      ST_SHIFT_IN: begin
        if (fall_s) begin
          sh_s  = {PGDx_in, sh_r[15:1]};
          bit_s = bit_r + 5'd1;
          if (bit_r == 5'd15) begin
            state_s  = ST_FIN;
            bit_s    = 5'd0;
            dout_s   = {PGDx_in, sh_r[15:1]};
            dvalid_s = 1'b1;
          end else begin
            dvalid_s = 1'b0;
          end
        end else begin
          sh_s = sh_r;
        end
      end
      ST_EXIT_LO: begin
        if (dly_r == DLY_M1) begin
          state_s   = ST_FIN;
          mclrn_s   = 1'b1;
          entered_s = 1'b0;
        end else begin
          dly_s = dly_r + 17'd1;
        end
      end
      default: state_s = ST_IDLE;
    endcase

    busy_s = !(state_s inside {ST_IDLE, ST_FIN});
    done_s = (state_s == ST_FIN);
    err_s  = (state_s == ST_FIN) && rej_s;
    dir_s  = (state_s inside {ST_KEY, ST_SHIFT_OUT}) ||
             ((state_s == ST_SHIFT_CMD) && !rej_s);
  end

  // State and output registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      op_r      <= OP_ENTER;
      bit_r     <= 5'd0;
      dly_r     <= 17'd0;
      instr_r   <= 24'd0;
      sh_r      <= 16'd0;
      dout_r    <= 16'd0;
      rej_r     <= 1'b0;
      entered_r <= 1'b0;
      pgd_r     <= 1'b0;
      dir_r     <= 1'b0;
      mclrn_r   <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      dvalid_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      op_r      <= op_s;
      bit_r     <= bit_s;
      dly_r     <= dly_s;
      instr_r   <= instr_s;
      sh_r      <= sh_s;
      dout_r    <= dout_s;
      rej_r     <= rej_s;
      entered_r <= entered_s;
      pgd_r     <= pgd_s;
      dir_r     <= dir_s;
      mclrn_r   <= mclrn_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
      dvalid_r  <= dvalid_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign dout     = dout_r;
  assign dvalid   = dvalid_r;
  assign PGCx     = pgc_s;
  assign PGDx_out = pgd_r;
  assign PGDx_dir = dir_r;
  assign MCLRn    = mclrn_r;

endmodule

// File: tb/tb_pic24_icsp_seq.sv
// Directed-plus-random bench for pic24_icsp_seq with a small PIC24 target model.
module tb_pic24_icsp_seq;
  localparam int CLKDIV = 2;
  localparam int DLY    = 8;
  localparam int BITC   = 2 * CLKDIV;
  localparam int ENTER_CYC = DLY + 32 * BITC + 2 * DLY + 1;
  localparam int SIX_CYC   = 28 * BITC + 1;
  localparam logic [1:0] C_ENTER = 2'd0, C_SIX = 2'd1, C_REGOUT = 2'd2, C_EXIT = 2'd3;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [1:0] op = 2'd0;
  logic [23:0] instr = 24'd0;
  logic busy, done, err, dvalid, PGCx, PGDx_out, PGDx_dir, MCLRn, PGDx_in;
  logic [15:0] dout;

  int vectors = 0, miscompares = 0;
  logic [1:0] rises[$];              // {dir, pgd} captured at each PGC rise
  int in_idx = 0, viol_pgd = 0, viol_pgc = 0;
  logic prev_pgc = 1'b0, prev_pgd = 1'b0, prev_rstn = 1'b0;
  logic [15:0] tgt_val = 16'd0;
  int base, ncyc, lowc;

  always #5 clk = ~clk;

  // Target answers REGOUT: after 8 turnaround clocks it presents bits LSB-first.
  assign PGDx_in = (in_idx >= 9 && in_idx <= 24) ? tgt_val[4'(in_idx - 9)] : 1'b0;

  pic24_icsp_seq #(.CLKDIV(CLKDIV), .DLY(DLY)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .instr(instr),
    .busy(busy), .done(done), .err(err), .dout(dout), .dvalid(dvalid),
    .PGCx(PGCx), .PGDx_out(PGDx_out), .PGDx_in(PGDx_in),
    .PGDx_dir(PGDx_dir), .MCLRn(MCLRn)
  );

  // Pin monitor: records the serial stream and flags protocol violations.
  always @(negedge clk) begin
    if (rstn && prev_rstn) begin
      if (PGCx && !prev_pgc) begin
        rises.push_back({PGDx_dir, PGDx_out});
        if (PGDx_dir) in_idx = 0;
        else          in_idx = in_idx + 1;
      end else if (PGDx_out !== prev_pgd) begin
        viol_pgd = viol_pgd + 1;
      end
      if (!busy && PGCx) viol_pgc = viol_pgc + 1;
    end
    prev_pgc  = PGCx;
    prev_pgd  = PGDx_out;
    prev_rstn = rstn;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stream_lsb(input int from, input int n);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++)
      if (from + i < rises.size()) v[i] = rises[from + i][0];
    return v;
  endfunction

  function automatic logic [31:0] stream_msb(input int from, input int n);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++)
      if (from + i < rises.size()) v = {v[30:0], rises[from + i][0]};
    return v;
  endfunction

  function automatic int dir_ones(input int from, input int n);
    int c = 0;
    for (int i = 0; i < n; i++)
      if (from + i < rises.size() && rises[from + i][1]) c++;
    return c;
  endfunction

  task automatic launch(input logic [1:0] o, input logic [23:0] ins);
    @(negedge clk);
    op = o; instr = ins; start = 1'b1; base = rises.size();
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget, output int n, output int low);
    n = 1;
    low = (MCLRn === 1'b0) ? 1 : 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
      if (MCLRn === 1'b0) low++;
    end
  endtask

  task automatic do_reject(input string tag);
    launch(C_SIX, 24'($urandom));
    wait_done(20, ncyc, lowc);
    check({tag, "_cycles"}, 32'(ncyc), 32'd2);
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_pulses"}, 32'(rises.size() - base), 32'd0);
  endtask

  task automatic do_enter();
    launch(C_ENTER, 24'd0);
    wait_done(400, ncyc, lowc);
    check("enter_cycles", 32'(ncyc), 32'(ENTER_CYC));
    check("enter_mclr_low", 32'(lowc), 32'(2 * DLY + 32 * BITC));
    check("enter_pulses", 32'(rises.size() - base), 32'd32);
    check("enter_key", stream_msb(base, 32), 32'h4D434851);
    check("enter_dir", 32'(dir_ones(base, 32)), 32'd32);
    check("enter_err", 32'(err), 32'd0);
    check("enter_mclr_hi", 32'(MCLRn), 32'd1);
  endtask

  task automatic do_six(input logic [23:0] v);
    launch(C_SIX, v);
    wait_done(400, ncyc, lowc);
    check("six_cycles", 32'(ncyc), 32'(SIX_CYC));
    check("six_pulses", 32'(rises.size() - base), 32'd28);
    check("six_stream", stream_lsb(base, 28), {4'd0, v, 4'b0000});
    check("six_dir", 32'(dir_ones(base, 28)), 32'd28);
    check("six_err_dv", {30'd0, err, dvalid}, 32'd0);
  endtask

  task automatic do_regout(input logic [15:0] v);
    tgt_val = v;
    launch(C_REGOUT, 24'd0);
    wait_done(400, ncyc, lowc);
    check("reg_cycles", 32'(ncyc), 32'(SIX_CYC));
    check("reg_done_dv", {30'd0, dvalid, err}, 32'd2);
    check("reg_dout", 32'(dout), 32'(v));
    check("reg_cmd", stream_lsb(base, 4), 32'd1);
    check("reg_dir", 32'(dir_ones(base, 4) * 100 + dir_ones(base + 4, 24)), 32'd400);
    check("reg_pulses", 32'(rises.size() - base), 32'd28);
  endtask

  initial begin
    int dcount;
    logic [15:0] held;
    logic [23:0] a, b;
    repeat (3) @(negedge clk);
    check("rst_ctl", {28'd0, busy, done, err, dvalid}, 32'd0);
    check("rst_pins", {28'd0, PGCx, PGDx_out, PGDx_dir, MCLRn}, 32'd1);
    check("rst_dout", 32'(dout), 32'd0);
    rstn = 1'b1;

    do_reject("rej_pre");
    do_enter();
    do_six(24'h040200);
    for (int i = 0; i < 3; i++) do_six(24'($urandom));
    do_regout(16'hA55A);
    for (int i = 0; i < 2; i++) do_regout(16'($urandom));
    held = dout;
    do_six(24'($urandom));
    check("dout_held", 32'(dout), 32'(held));
    do_enter();

    // start held high: one acceptance per idle window, back-to-back restart
    a = 24'($urandom); b = 24'($urandom);
    @(negedge clk);
    op = C_SIX; instr = a; start = 1'b1; base = rises.size();
    wait_done(400, ncyc, lowc);
    ncyc = ncyc - 1;
    check("b2b_first_cycles", 32'(ncyc), 32'(SIX_CYC));
    check("b2b_first_pulses", 32'(rises.size() - base), 32'd28);
    instr = b;
    @(negedge clk);
    check("b2b_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(400, ncyc, lowc);
    check("b2b_second_cycles", 32'(ncyc), 32'(SIX_CYC));
    check("b2b_stream", stream_lsb(base + 28, 28), {4'd0, b, 4'b0000});

    launch(C_EXIT, 24'd0);
    wait_done(50, ncyc, lowc);
    check("exit_cycles", 32'(ncyc), 32'(DLY + 1));
    check("exit_mclr_low", 32'(lowc), 32'(DLY));
    check("exit_pins", {30'd0, MCLRn, PGDx_dir}, 32'd2);
    do_reject("rej_exit");

    // reset in the middle of a SIX
    do_enter();
    launch(C_SIX, 24'($urandom));
    for (int i = 0; i < 60 && !(PGCx && i > 20); i++) @(negedge clk);
    check("mid_pgc_high", 32'(PGCx), 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_ctl", {28'd0, busy, done, err, dvalid}, 32'd0);
    check("mid_rst_pins", {28'd0, PGCx, PGDx_out, PGDx_dir, MCLRn}, 32'd1);
    check("mid_rst_dout", 32'(dout), 32'd0);
    dcount = 0;
    repeat (3) begin @(negedge clk); if (done) dcount++; end
    rstn = 1'b1;
    repeat (150) begin @(negedge clk); if (done) dcount++; end
    check("mid_no_done", 32'(dcount), 32'd0);
    do_reject("rej_rst");

    check("pgd_change_only_at_rise", 32'(viol_pgd), 32'd0);
    check("pgc_low_when_idle", 32'(viol_pgc), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pic24_icsp_seq.md
PIC24_ICSP_SEQ -- requirements
Module: pic24_icsp_seq

Interface
REQ-001 SHALL have parameter CLKDIV, default 4: PGCx half-period in clk cycles (range 2..255).
REQ-002 SHALL have parameter DLY, default 1000: MCLRn settle/hold delay in clk cycles (range 1..65535).
REQ-003 SHALL have port clk, input, 1: the single system clock.
REQ-004 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1: command request, sampled only while busy=0.
REQ-006 SHALL have port op, input, 2: command code (0 ENTER, 1 SIX, 2 REGOUT, 3 EXIT).
REQ-007 SHALL have port instr, input, 24: SIX payload, captured when start is accepted.
REQ-008 SHALL have port busy, output, 1: a command is in progress.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port err, output, 1: qualifies done; SIX/REGOUT was rejected.
REQ-011 SHALL have port dout, output, 16: REGOUT result, held until the next REGOUT completes.
REQ-012 SHALL have port dvalid, output, 1: one-cycle pulse, coincident with done, for a successful REGOUT.
REQ-013 SHALL have ports PGCx (out, 1), PGDx_out (out, 1), PGDx_in (in, 1), PGDx_dir (out, 1; 1 = host drives PGD) and MCLRn (out, 1) to the target.

Function
REQ-014 SHALL accept start only when busy=0; busy SHALL rise the next cycle; start while busy=1 SHALL be ignored.
REQ-015 SHALL use an FSM with states IDLE, MCLR_LO, KEY, MCLR_WAIT, SHIFT_CMD, SHIFT_OUT, TURN, SHIFT_IN, EXIT_LO and FIN.
REQ-016 Each PGCx bit period SHALL be 2*CLKDIV clk cycles, PGCx low first.
REQ-017 PGDx_out SHALL change only at a PGCx rising edge.
REQ-018 PGDx_in SHALL be sampled in the clk cycle in which PGCx falls.
REQ-019 ENTER SHALL drive MCLRn=0 for DLY cycles, then shift 32-bit key 0x4D434851 MSB-first with PGDx_dir=1.
REQ-020 ENTER SHALL then wait DLY cycles and raise MCLRn=1, then wait DLY more cycles before done; it SHALL set the internal entered flag.
REQ-021 SIX SHALL shift 4'b0000 then instr[23:0], all LSB-first: 28 bit periods.
REQ-022 REGOUT SHALL shift 4'b0001 LSB-first, then drive PGDx_dir=0 for 8 idle clocks.
REQ-023 REGOUT SHALL then capture 16 bits LSB-first into dout; its total is 28 bit periods.
REQ-024 EXIT SHALL set PGDx_dir=0 and MCLRn=0 for DLY cycles, then MCLRn=1, clear entered, and signal done.
REQ-025 SIX/REGOUT with entered=0 SHALL produce no PGCx activity and pulse done and err together 2 cycles after start.
REQ-026 ENTER while entered=1 SHALL re-run the full entry sequence.
REQ-027 done SHALL pulse in FIN and busy SHALL drop in the same cycle, so a back-to-back start is accepted the next cycle.
REQ-028 PGCx SHALL be 0 whenever busy=0.

Reset
REQ-029 On rstn=0, immediately and asynchronously: FSM=IDLE; PGCx=0, PGDx_out=0, PGDx_dir=0, MCLRn=1; busy, done, err, dvalid=0; dout=0; entered=0.
REQ-030 Reset mid-command SHALL abort the command with no done pulse.

Structure
REQ-031 Package icsp_pkg SHALL hold the op codes, the ICSP key constant, the 4-bit SIX/REGOUT command codes and the FSM state enum.
REQ-032 The design SHALL contain one sub-module, icsp_bitclk: a CLKDIV counter emitting rise/fall ticks and driving PGCx.

Verification (CLKDIV=2, DLY=8)
REQ-033 Reset then ENTER -> MCLRn low 8 cycles; 32 PGCx pulses carry 0x4D434851 MSB-first; MCLRn rises; done at cycle 8+128+8+8(+handshake).
REQ-034 SIX with instr=0x040200 after ENTER -> 28 PGCx pulses, serial bits 0000 then 0x040200 LSB-first, done after 112 cycles.
REQ-035 REGOUT with a target model returning 0xA55A -> PGDx_dir=0 from bit 4 onward; dout=0xA55A; dvalid and done pulse together.
REQ-036 SIX before any ENTER -> done=err=1 two cycles after start; PGCx stays 0.
REQ-037 rstn asserted mid-SIX -> all outputs at reset values in the same cycle; no done; a subsequent SIX gives err=1.
REQ-038 start held high during a command, then back-to-back SIX -> exactly one command per acceptance; second busy rises the cycle after the first done.
